// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave with a parametrised register bank: RW, RO and clear-on-read registers,
// byte strobes, SLVERR on bad accesses, and independent write/read channel state machines.
module axi4_lite_reg_bank #(
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                    NUM_REGS         = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK          = '0,
    parameter logic [NUM_REGS-1:0]   COR_MASK         = '0,
    parameter int                    ADD_READ_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_data,
    output logic [NUM_REGS-1:0]            o_write_pulse,
    output logic [NUM_REGS-1:0]            o_read_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W    = (ADD_READ_LATENCY > 0) ? $clog2(ADD_READ_LATENCY + 1) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_VALID = 2'd2} r_state_t;
    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        logic [ADDR_WIDTH-1:0] word;
        dec_t                  d;
        off   = addr - BASE_ADDR;
        word  = off >> OFF_BITS;
        d.idx = word[IDX_W-1:0];
        if ((off[OFF_BITS-1:0] == '0) && (word < ADDR_WIDTH'(NUM_REGS))) d.hit = 1'b1;
        else d.hit = 1'b0;
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] cur,
                                                          input logic [DATA_WIDTH-1:0] nxt,
                                                          input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] res;
        res = cur;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = nxt[b*8 +: 8];
            else res[b*8 +: 8] = cur[b*8 +: 8];
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] hw_arr_s [NUM_REGS];

    w_state_t              w_state_r, w_state_s;
    logic                  aw_done_r, w_done_r, awready_r, wready_r, bvalid_r;
    logic [1:0]            bresp_r;
    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]     wstrb_r;
    logic                  aw_hs_s, w_hs_s, wr_ok_s, wr_en_s;
    dec_t                  wr_dec_s;

    r_state_t              r_state_r, r_state_s;
    logic                  arready_r, rvalid_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r, rd_data_s;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  ar_hs_s, rd_sample_s, rd_en_s, cor_clr_s;
    dec_t                  rd_dec_s;

    logic [NUM_REGS-1:0]   write_pulse_r, read_pulse_r;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_map
            assign o_reg_data[gi*DATA_WIDTH +: DATA_WIDTH] = regs_r[gi];
            assign hw_arr_s[gi] = i_hw_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign awready       = awready_r;
    assign wready        = wready_r;
    assign bvalid        = bvalid_r;
    assign bresp         = bresp_r;
    assign arready       = arready_r;
    assign rvalid        = rvalid_r;
    assign rresp         = rresp_r;
    assign rdata         = rdata_r;
    assign o_write_pulse = write_pulse_r;
    assign o_read_pulse  = read_pulse_r;

    // Write channel next state and write decode
    always_comb begin
        aw_hs_s   = awvalid && awready_r;
        w_hs_s    = wvalid && wready_r;
        w_state_s = w_state_r;
        case (w_state_r)
            W_COLLECT: begin
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) w_state_s = W_EXEC;
                else w_state_s = W_COLLECT;
            end
            W_EXEC:  w_state_s = W_RESP;
            W_RESP: begin
                if (bready) w_state_s = W_COLLECT;
                else w_state_s = W_RESP;
            end
            default: w_state_s = W_COLLECT;
        endcase
        wr_dec_s = decode(awaddr_r);
        wr_ok_s  = wr_dec_s.hit && !RO_MASK[wr_dec_s.idx];
        wr_en_s  = (w_state_r == W_EXEC) && wr_ok_s;
    end

    // Write channel registers: AW/W capture, readies and B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_COLLECT;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
        end else begin
            w_state_r <= w_state_s;
            case (w_state_r)
                W_COLLECT: begin
                    if (aw_hs_s) awaddr_r <= awaddr;
                    if (w_hs_s) begin
                        wdata_r <= wdata;
                        wstrb_r <= wstrb;
                    end
                    if (w_state_s == W_EXEC) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                    end else begin
                        aw_done_r <= aw_done_r || aw_hs_s;
                        w_done_r  <= w_done_r || w_hs_s;
                        awready_r <= !(aw_done_r || aw_hs_s);
                        wready_r  <= !(w_done_r || w_hs_s);
                    end
                end
                W_EXEC: begin
                    bvalid_r <= 1'b1;
                    bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: bvalid_r <= 1'b0;
            endcase
        end
    end

    // Read channel next state, read data mux and clear-on-read decision
    always_comb begin
        ar_hs_s     = arvalid && arready_r;
        rd_sample_s = (r_state_r == R_WAIT) && (cnt_r == '0);
        r_state_s   = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_WAIT;
                else r_state_s = R_IDLE;
            end
            R_WAIT: begin
                if (rd_sample_s) r_state_s = R_VALID;
                else r_state_s = R_WAIT;
            end
            R_VALID: begin
                if (rready) r_state_s = R_IDLE;
                else r_state_s = R_VALID;
            end
            default: r_state_s = R_IDLE;
        endcase
        rd_dec_s  = decode(araddr_r);
        rd_data_s = '0;
        if (!rd_dec_s.hit) rd_data_s = '0;
        else if (RO_MASK[rd_dec_s.idx]) rd_data_s = hw_arr_s[rd_dec_s.idx];
        else rd_data_s = regs_r[rd_dec_s.idx];
        rd_en_s   = rd_sample_s && rd_dec_s.hit;
        cor_clr_s = rd_en_s && COR_MASK[rd_dec_s.idx] && !RO_MASK[rd_dec_s.idx];
    end

    // Read channel registers: AR capture, latency counter and R response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
            araddr_r  <= '0;
            cnt_r     <= '0;
        end else begin
            r_state_r <= r_state_s;
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        araddr_r  <= araddr;
                        arready_r <= 1'b0;
                        cnt_r     <= CNT_W'(ADD_READ_LATENCY);
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rd_sample_s) begin
                        rvalid_r <= 1'b1;
                        rdata_r  <= rd_data_s;
                        rresp_r  <= rd_dec_s.hit ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                R_VALID: begin
                    if (rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end
                end
                default: rvalid_r <= 1'b0;
            endcase
        end
    end

    // Register bank and access pulses; a write beats a clear-on-read to the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
            write_pulse_r <= '0;
            read_pulse_r  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (wr_dec_s.idx == IDX_W'(i)))
                    regs_r[i] <= merge_bytes(regs_r[i], wdata_r, wstrb_r);
                else if (cor_clr_s && (rd_dec_s.idx == IDX_W'(i)))
                    regs_r[i] <= '0;
                else
                    regs_r[i] <= regs_r[i];
            end
            write_pulse_r <= wr_en_s ? (NUM_REGS'(1) << wr_dec_s.idx) : '0;
            read_pulse_r  <= rd_en_s ? (NUM_REGS'(1) << rd_dec_s.idx) : '0;
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Scoreboard bench for axi4_lite_reg_bank: expected responses are queued when a request is
// issued and compared when the matching B or R beat appears.
module tb_axi4_lite_reg_bank;
    localparam int          NR       = 16;
    localparam int          LAT      = 2;
    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam logic [15:0] RO_MASK  = 16'h0001;
    localparam logic [15:0] COR_MASK = 16'h0008;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]    wstrb = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [NR*32-1:0] o_reg_data, i_hw_data;
    logic [NR-1:0] o_write_pulse, o_read_pulse;

    axi4_lite_reg_bank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .NUM_REGS(NR),
        .RO_MASK(RO_MASK), .COR_MASK(COR_MASK), .ADD_READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .o_reg_data(o_reg_data), .i_hw_data(i_hw_data),
        .o_write_pulse(o_write_pulse), .o_read_pulse(o_read_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [15:0] pulse;
        int          idx;
    } exp_t;

    exp_t        wq[$];
    exp_t        rq[$];
    logic [31:0] mdl [NR];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Issue AW and W (W delayed by w_lag cycles); queue expected B beat and update the model.
    task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int w_lag, input bit ok, input int idx, output int aw_cyc);
        bit   aw_d = 1'b0, w_d = 1'b0;
        exp_t e;
        if (ok) begin
            for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        e.data  = 32'h0;
        e.resp  = ok ? 2'b00 : 2'b10;
        e.pulse = ok ? (16'h1 << idx) : 16'h0;
        e.idx   = idx;
        wq.push_back(e);
        awaddr = addr; wdata = data; wstrb = strb; aw_cyc = -1;
        for (int t = 0; t < 40 && !(aw_d && w_d); t++) begin
            awvalid = !aw_d;
            wvalid  = !w_d && (t >= w_lag);
            if (awvalid && awready) begin aw_d = 1'b1; aw_cyc = cyc; end
            if (wvalid && wready) w_d = 1'b1;
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_d && w_d)) check_val("aw_w_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_write(input int hold, input bit chk_pulse, output int b_cyc);
        exp_t e;
        b_cyc = -1;
        for (int t = 0; t < 40 && !bvalid; t++) @(negedge clk);
        if (!bvalid) begin check_val("b_timeout", 64'd0, 64'd1); wq.delete(); return; end
        if (wq.size() == 0) begin check_val("b_unexpected", 64'd1, 64'd0); return; end
        b_cyc = cyc;
        e = wq.pop_front();
        if (chk_pulse) check_val("wr_pulse", o_write_pulse, e.pulse);
        check_val("bresp", bresp, e.resp);
        if (e.idx >= 0) check_val("reg_data", o_reg_data[e.idx*32 +: 32], mdl[e.idx]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("b_hold", {bvalid, bresp}, {1'b1, e.resp});
        end
        bready = 1'b1; @(negedge clk); bready = 1'b0;
        check_val("b_done", {bvalid, o_write_pulse}, 64'd0);
    endtask

    // Issue AR; queue expected R beat (RO -> hw input, COR clears the model copy).
    task automatic start_read(input logic [31:0] addr, input bit ok, input int idx, output int ar_cyc);
        exp_t e;
        e.idx   = ok ? idx : -1;
        e.resp  = ok ? 2'b00 : 2'b10;
        e.pulse = ok ? (16'h1 << idx) : 16'h0;
        if (!ok) e.data = 32'h0;
        else if (RO_MASK[idx]) e.data = i_hw_data[idx*32 +: 32];
        else begin
            e.data = mdl[idx];
            if (COR_MASK[idx]) mdl[idx] = 32'h0;
        end
        rq.push_back(e);
        araddr = addr; ar_cyc = -1;
        for (int t = 0; t < 40 && ar_cyc < 0; t++) begin
            arvalid = 1'b1;
            if (arready) ar_cyc = cyc;
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (ar_cyc < 0) check_val("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_read(input int hold, input int ar_cyc);
        exp_t e;
        for (int t = 0; t < 40 && !rvalid; t++) @(negedge clk);
        if (!rvalid) begin check_val("r_timeout", 64'd0, 64'd1); rq.delete(); return; end
        if (rq.size() == 0) begin check_val("r_unexpected", 64'd1, 64'd0); return; end
        e = rq.pop_front();
        if (ar_cyc >= 0) check_val("r_latency", 64'(cyc - ar_cyc), 64'(2 + LAT));
        check_val("rdata", rdata, e.data);
        check_val("rresp", rresp, e.resp);
        check_val("rd_pulse", o_read_pulse, e.pulse);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("r_hold", {rvalid, rresp, rdata}, {1'b1, e.resp, e.data});
        end
        rready = 1'b1; @(negedge clk); rready = 1'b0;
        check_val("r_done", {rvalid, o_read_pulse}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a, b;
        bit          seen;
        logic [31:0] bad_addr [3];
        bad_addr[0] = BASE + 32'h40;
        bad_addr[1] = BASE + 32'h2;
        bad_addr[2] = BASE - 32'h4;
        i_hw_data = '0;
        i_hw_data[31:0]       = 32'h0000_CAFE;
        i_hw_data[5*32 +: 32] = 32'h5555_AAAA;
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;

        repeat (3) @(negedge clk);
        check_val("rst_ready", {awready, wready, arready}, 64'd0);
        check_val("rst_valid", {bvalid, rvalid, bresp, rresp}, 64'd0);
        check_val("rst_out", {o_write_pulse, o_read_pulse, rdata}, 64'd0);
        check_val("rst_regs", {63'd0, |o_reg_data}, 64'd0);
        rst_n = 1'b1;
        #1 check_val("ready_at_release", {awready, wready, arready}, 64'd0);
        @(negedge clk);
        check_val("ready_after_release", {awready, wready, arready}, 64'd7);

        // Split AW/W, full strobe
        start_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 3, 1'b1, 1, a);
        finish_write(0, 1'b1, b);
        check_val("b_latency_split", 64'(b - a), 64'd5);

        // Byte strobes
        start_write(BASE + 32'h8, 32'h1122_3344, 4'hF, 0, 1'b1, 2, a);
        finish_write(0, 1'b1, b);
        check_val("b_latency_joint", 64'(b - a), 64'd2);
        start_write(BASE + 32'h8, 32'hAABB_CCDD, 4'h5, 0, 1'b1, 2, a);
        finish_write(0, 1'b1, b);
        check_val("reg2_merge", o_reg_data[2*32 +: 32], 64'h11BB_33DD);
        start_read(BASE + 32'h8, 1'b1, 2, a);
        finish_read(0, a);

        // Back-pressured read
        start_read(BASE + 32'h4, 1'b1, 1, a);
        finish_read(10, a);

        // Unmapped, misaligned, below-base
        for (int k = 0; k < 3; k++) begin
            start_read(bad_addr[k], 1'b0, 0, a);
            finish_read(0, a);
            start_write(bad_addr[k], 32'hFFFF_FFFF, 4'hF, 0, 1'b0, -1, a);
            finish_write(0, 1'b1, b);
        end

        // Read-only register
        start_read(BASE, 1'b1, 0, a);
        finish_read(0, a);
        start_write(BASE, 32'h1234_5678, 4'hF, 0, 1'b0, 0, a);
        finish_write(0, 1'b1, b);

        // RW register with live hw input must return register contents
        start_write(BASE + 32'h14, 32'h1234_5678, 4'hF, 1, 1'b1, 5, a);
        finish_write(0, 1'b1, b);
        start_read(BASE + 32'h14, 1'b1, 5, a);
        finish_read(0, a);

        // Clear-on-read
        start_write(BASE + 32'hC, 32'h5, 4'hF, 0, 1'b1, 3, a);
        finish_write(0, 1'b1, b);
        start_read(BASE + 32'hC, 1'b1, 3, a);
        finish_read(0, a);
        check_val("cor_cleared", o_reg_data[3*32 +: 32], 64'h0);
        start_read(BASE + 32'hC, 1'b1, 3, a);
        finish_read(0, a);

        // Write lands in the same cycle as the clear: read sees old value, write survives
        start_write(BASE + 32'hC, 32'h7, 4'hF, 0, 1'b1, 3, a);
        finish_write(0, 1'b1, b);
        start_read(BASE + 32'hC, 1'b1, 3, a);
        @(negedge clk);
        start_write(BASE + 32'hC, 32'h9, 4'hF, 0, 1'b1, 3, b);
        finish_read(0, a);
        finish_write(0, 1'b0, b);
        check_val("cor_write_wins", o_reg_data[3*32 +: 32], 64'h9);
        start_read(BASE + 32'hC, 1'b1, 3, a);
        finish_read(0, a);

        // Zero strobe: pulse and OKAY, data unchanged
        start_write(BASE + 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 1'b1, 4, a);
        finish_write(0, 1'b1, b);
        start_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 1'b1, 4, a);
        finish_write(0, 1'b1, b);
        check_val("strb0_keep", o_reg_data[4*32 +: 32], 64'hA5A5_A5A5);

        // Back-pressured write response
        start_write(BASE + 32'h18, 32'h0000_600D, 4'hF, 0, 1'b1, 6, a);
        finish_write(10, 1'b1, b);

        // Reset while the read is waiting
        start_read(BASE + 32'h4, 1'b1, 1, a);
        rst_n = 1'b0;
        #1 check_val("ready_in_reset", {awready, wready, arready, rvalid}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
        wq.delete();
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        seen = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            seen = seen | rvalid;
        end
        check_val("rvalid_after_drop", {63'd0, seen}, 64'd0);
        check_val("regs_after_reset", {63'd0, |o_reg_data}, 64'd0);
        start_read(BASE + 32'h4, 1'b1, 1, a);
        finish_read(0, a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
